// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter merging NumReq write streams into one fifo write port
module fifo_wr_arbiter #(
  parameter int NumReq     = 4,
  parameter int WordLength = 8,
  parameter int MaxBurst   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumReq-1:0]            req_valid_i,
  input  logic [NumReq*WordLength-1:0] req_data_i,
  output logic [NumReq-1:0]            req_ready_o,
  output logic                         fifo_wr_o,
  output logic [WordLength-1:0]        fifo_w_data_o,
  input  logic                         fifo_full_i,
  output logic [NumReq-1:0]            grant_o,
  output logic                         busy_o
);
  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = $clog2(MaxBurst + 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  logic [0:0]      state_q, state_d;
  logic [IdxW-1:0] g_q, g_d, p_q, p_d, sel, cand, g_nxt;
  logic [IdxW:0]   sum;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            found, xfer;
  assign busy_o        = state_q == GRANT;
  assign xfer          = busy_o && req_valid_i[g_q] && !fifo_full_i;
  assign fifo_wr_o     = xfer;
  assign grant_o       = busy_o ? NumReq'(1) << g_q : '0;
  assign req_ready_o   = busy_o && !fifo_full_i ? grant_o : '0;
  assign fifo_w_data_o = busy_o ? req_data_i[g_q*WordLength +: WordLength] : '0;
  assign g_nxt         = (g_q == IdxW'(NumReq - 1)) ? '0 : g_q + 1'b1;
  // first valid requester searching p, p+1, ... with wrap at NumReq
  always_comb begin
    sel   = p_q;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NumReq; i++) begin
      sum  = {1'b0, p_q} + (IdxW+1)'(i);
      cand = (sum >= (IdxW+1)'(NumReq)) ? IdxW'(sum - (IdxW+1)'(NumReq)) : IdxW'(sum);
      if (!found && req_valid_i[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end
  // arbitrate in IDLE; count burst and release in GRANT; a full fifo freezes everything
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    if (!busy_o) begin
      if (found) begin
        state_d = GRANT;
        g_d     = sel;
        cnt_d   = '0;
      end
    end else if (!fifo_full_i) begin
      cnt_d = xfer ? cnt_q + 1'b1 : cnt_q;
      if (!req_valid_i[g_q] || cnt_q == CntW'(MaxBurst - 1)) begin
        state_d = IDLE;
        p_d     = g_nxt;
      end
    end
  end
  // state registers, cleared asynchronously so a mid-burst reset aborts at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      g_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NumReq, default 4, number of write requesters (2..8).
REQ-002 The block SHALL have parameter WordLength, default 8, data width matching the fifo write port.
REQ-003 The block SHALL have parameter MaxBurst, default 4, maximum words accepted per grant (1..15).
REQ-004 The block SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 The block SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port req_valid_i  input  NumReq  per-requester write request/data valid.
REQ-007 The block SHALL have port req_data_i  input  NumReq*WordLength  requester k data at bits [k*WordLength +: WordLength].
REQ-008 The block SHALL have port req_ready_o  output  NumReq  per-requester accept.
REQ-009 The block SHALL have port fifo_wr_o  output  1  write strobe to fifo wr_i.
REQ-010 The block SHALL have port fifo_w_data_o  output  WordLength  data to fifo w_data_i.
REQ-011 The block SHALL have port fifo_full_i  input  1  fifo full_o.
REQ-012 The block SHALL have port grant_o  output  NumReq  one-hot current owner, all zero in IDLE.
REQ-013 The block SHALL have port busy_o  output  1  high in GRANT state.

Function
REQ-014 The FSM SHALL have two states, IDLE and GRANT, plus registers grant index g, round-robin pointer p, and burst counter cnt (clog2(MaxBurst+1) bits).
REQ-015 In IDLE with any req_valid_i high, the FSM SHALL select the first valid requester searching p, p+1, ... mod NumReq, load g, clear cnt and enter GRANT next cycle; otherwise it SHALL stay in IDLE.
REQ-016 In IDLE, req_ready_o and fifo_wr_o SHALL be 0.
REQ-017 In GRANT, req_ready_o[g] SHALL equal ~fifo_full_i (combinational), and all other ready bits SHALL be 0.
REQ-018 In GRANT, fifo_wr_o SHALL equal req_valid_i[g] & ~fifo_full_i, and fifo_w_data_o SHALL equal requester g data in the same cycle (zero latency).
REQ-019 A transfer (valid & ready on g) SHALL increment cnt by 1.
REQ-020 GRANT SHALL release to IDLE next cycle when a transfer brings cnt to MaxBurst, or when req_valid_i[g] is low in a cycle with fifo_full_i low.
REQ-021 On release, p SHALL load (g+1) mod NumReq.
REQ-022 With fifo_full_i high in GRANT, the FSM SHALL hold g, cnt and state (stall), issue no write, and SHALL NOT release even if req_valid_i[g] drops.
REQ-023 Back-to-back grants SHALL include exactly one IDLE cycle; first word of a grant SHALL be accepted no earlier than 1 cycle after arbitration.
REQ-024 fifo_wr_o SHALL never assert while fifo_full_i is high.
REQ-025 Valid changes on non-granted requesters SHALL NOT affect the current grant.

Reset
REQ-026 While rst_ni is low, state SHALL be IDLE, g=0, p=0, cnt=0, and req_ready_o, fifo_wr_o, grant_o, busy_o SHALL be 0; fifo_w_data_o SHALL be 0.
REQ-027 Reset asserted mid-burst SHALL abort immediately; no write SHALL be issued in the reset cycle; arbitration SHALL restart from p=0 after release.

Verification
REQ-028 Single requester: valid[1]=1 with 6 words, full=0 -> grant_o=0010 from cycle 2, 4 writes, 1 IDLE cycle, re-grant to req 1, remaining 2 words written.
REQ-029 Round-robin: all 4 valid continuously -> grant order 0,1,2,3,0, each for 4 words, one idle cycle between.
REQ-030 Full stall: grant to req 2, fifo_full_i=1 for 3 cycles after 1st word -> no fifo_wr_o, ready[2]=0, cnt stays 1, burst resumes and completes 4 words.
REQ-031 Early release: req 0 supplies 2 words then drops valid -> IDLE next cycle, p=1.
REQ-032 Reset mid-burst: rst_ni low after 2nd word of req 3 -> all outputs 0 same cycle, next grant after reset to lowest valid index from 0.
REQ-033 Scoreboard: every fifo_wr_o word SHALL match the granted requester's data in order, with no writes while full.
